// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: round-robin arbiter for two requesters sharing a 2:1 word
// mux. It drives the mux select from the registered grant and captures the
// selected word into a valid/ready output register. Grants are held for at
// most MAX_BURST words so that neither requester can starve the other.
module mux_bus_arbiter #(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             out_ready,
   output logic             gnt0,
   output logic             gnt1,
   output logic             select,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last;            // requester granted most recently
   logic             last_nxt;
   logic [CNT_W-1:0] burst_cnt;       // words moved under the current grant
   logic [CNT_W-1:0] burst_cnt_nxt;
   logic             turn;            // first cycle after a direct hand-over
   logic             turn_nxt;
   logic             slot_free;
   logic             load0;
   logic             load1;
   logic             burst_end;

   assign gnt0   = (state == G0);
   assign gnt1   = (state == G1);
   assign select = gnt1;

   // The output register can take a word when empty or being drained now.
   assign slot_free = !out_valid || out_ready;

   // A direct hand-over flips the mux select; the newly granted side gets
   // one dead cycle before its first capture so the select settles first.
   assign load0 = gnt0 && req0 && slot_free && !turn;
   assign load1 = gnt1 && req1 && slot_free && !turn;
   assign ack0  = load0;
   assign ack1  = load1;

   assign burst_end = (burst_cnt == CNT_W'(MAX_BURST - 1));

   // Next grant: round-robin on ties from IDLE, release on withdraw or on
   // the final load of a burst, hand straight over when the other side waits.
   always_comb begin
      state_nxt     = state;
      last_nxt      = last;
      burst_cnt_nxt = burst_cnt;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = last ? G0 : G1;
            end else if (req0) begin
               state_nxt = G0;
            end else if (req1) begin
               state_nxt = G1;
            end
         end
         G0: begin
            if (load0) begin
               burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
            if (!req0 || (load0 && burst_end)) begin
               last_nxt      = 1'b0;
               burst_cnt_nxt = '0;
               state_nxt     = req1 ? G1 : IDLE;
            end
         end
         G1: begin
            if (load1) begin
               burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
            if (!req1 || (load1 && burst_end)) begin
               last_nxt      = 1'b1;
               burst_cnt_nxt = '0;
               state_nxt     = req0 ? G0 : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Flag the cycle that follows a grant moving directly between requesters.
   always_comb begin
      turn_nxt = ((state == G0) && (state_nxt == G1)) ||
                 ((state == G1) && (state_nxt == G0));
   end

   // Grant state, round-robin history, burst count and hand-over flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
         turn      <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_cnt_nxt;
         turn      <= turn_nxt;
      end
   end

   // Output register: capture the granted word, hold it under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load0) begin
         out_valid <= 1'b1;
         out_data  <= in0;
      end else if (load1) begin
         out_valid <= 1'b1;
         out_data  <= in1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: directed sequences with hand-derived cycle
// expectations plus a scoreboard that queues every acknowledged word and
// checks in-order delivery on each output handshake.
module tb_mux_bus_arbiter;

   localparam int WIDTH     = 16;
   localparam int MAX_BURST = 4;
   localparam int CNT_W     = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             out_ready;
   logic             gnt0;
   logic             gnt1;
   logic             select;
   logic             ack0;
   logic             ack1;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;

   int               n_chk  = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               wait0;
   int               wait1;
   logic             a0;
   logic             a1;
   logic [19:0]      e_ack0;
   logic [19:0]      e_ack1;
   logic [19:0]      e_gnt0;
   logic [19:0]      e_gnt1;

   always #5 clk = ~clk;

   mux_bus_arbiter #(
      .WIDTH    (WIDTH),
      .MAX_BURST(MAX_BURST),
      .CNT_W    (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .in0      (in0),
      .in1      (in1),
      .out_ready(out_ready),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .select   (select),
      .ack0     (ack0),
      .ack1     (ack1),
      .out_data (out_data),
      .out_valid(out_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_edge();
      @(negedge clk);
   endtask

   // Scoreboard monitor: pops on each output handshake, pushes on each ack.
   task automatic monitor_loop();
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            wait0 = 0;
            wait1 = 0;
         end else begin
            chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            chk("select_is_gnt1", 32'(select), 32'(gnt1));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("word_expected", 32'(exp_q.size()), 32'd1);
               else chk("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (ack0) begin
               chk("wait0_bound", 32'(wait0 <= MAX_BURST + 1), 32'd1);
               wait0 = 0;
            end else if (req0 && ack1) begin
               wait0++;
            end
            if (ack1) begin
               chk("wait1_bound", 32'(wait1 <= MAX_BURST + 1), 32'd1);
               wait1 = 0;
            end else if (req1 && ack0) begin
               wait1++;
            end
            if (!req0) wait0 = 0;
            if (!req1) wait1 = 0;
            if (ack0) exp_q.push_back(in0);
            if (ack1) exp_q.push_back(in1);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      in0 = '0; in1 = '0; out_ready = 1'b0;
      wait0 = 0; wait1 = 0;
      fork
         monitor_loop();
      join_none

      // Reset state, then a single word from requester 0.
      repeat (2) @(posedge clk);
      sample_edge();
      chk("t1_rst_gnt0", 32'(gnt0), 32'd0);
      chk("t1_rst_gnt1", 32'(gnt1), 32'd0);
      chk("t1_rst_select", 32'(select), 32'd0);
      chk("t1_rst_ack0", 32'(ack0), 32'd0);
      chk("t1_rst_ack1", 32'(ack1), 32'd0);
      chk("t1_rst_valid", 32'(out_valid), 32'd0);
      chk("t1_rst_data", 32'(out_data), 32'd0);
      drive_edge(); rst = 1'b0; req0 = 1'b1; in0 = 16'h0F00; out_ready = 1'b1;
      sample_edge();
      chk("t1_idle_gnt0", 32'(gnt0), 32'd0);
      chk("t1_idle_ack0", 32'(ack0), 32'd0);
      drive_edge();
      sample_edge();
      chk("t1_gnt0", 32'(gnt0), 32'd1);
      chk("t1_ack0", 32'(ack0), 32'd1);
      chk("t1_valid_lat", 32'(out_valid), 32'd0);
      drive_edge(); req0 = 1'b0;
      sample_edge();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data", 32'(out_data), 32'h0F00);
      chk("t1_no_ack", 32'(ack0), 32'd0);
      drive_edge();
      sample_edge();
      chk("t1_release", 32'(gnt0), 32'd0);
      chk("t1_drained", 32'(out_valid), 32'd0);

      // Both requesters continuously active: bursts of 4 with one dead cycle.
      drive_edge(); rst = 1'b1;
      drive_edge(); rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      in0 = 16'h0100; in1 = 16'h0200; out_ready = 1'b1;
      e_ack0 = 20'b00000_11110_00000_11110;
      e_ack1 = 20'b11110_00000_11110_00000;
      e_gnt0 = 20'b00000_11111_00000_11110;
      e_gnt1 = 20'b11111_00000_11111_00000;
      for (int c = 0; c < 20; c++) begin
         sample_edge();
         chk($sformatf("t2_ack0_c%0d", c), 32'(ack0), 32'(e_ack0[c]));
         chk($sformatf("t2_ack1_c%0d", c), 32'(ack1), 32'(e_ack1[c]));
         chk($sformatf("t2_gnt0_c%0d", c), 32'(gnt0), 32'(e_gnt0[c]));
         chk($sformatf("t2_gnt1_c%0d", c), 32'(gnt1), 32'(e_gnt1[c]));
         a0 = ack0; a1 = ack1;
         drive_edge();
         if (a0) in0 = in0 + 16'd1;
         if (a1) in1 = in1 + 16'd1;
      end
      req0 = 1'b0; req1 = 1'b0;

      // Backpressure while requester 1 holds the grant.
      drive_edge(); rst = 1'b1;
      drive_edge(); rst = 1'b0; req1 = 1'b1; in1 = 16'h1111; out_ready = 1'b0;
      sample_edge();
      chk("t3_idle_gnt1", 32'(gnt1), 32'd0);
      drive_edge();
      sample_edge();
      chk("t3_gnt1", 32'(gnt1), 32'd1);
      chk("t3_ack1", 32'(ack1), 32'd1);
      drive_edge(); in1 = 16'h2222;
      for (int c = 0; c < 5; c++) begin
         sample_edge();
         chk($sformatf("t3_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("t3_hold_data_c%0d", c), 32'(out_data), 32'h1111);
         chk($sformatf("t3_hold_noack_c%0d", c), 32'(ack1), 32'd0);
         chk($sformatf("t3_hold_gnt1_c%0d", c), 32'(gnt1), 32'd1);
         drive_edge();
      end
      out_ready = 1'b1;
      sample_edge();
      chk("t3_resume_ack", 32'(ack1), 32'd1);
      chk("t3_resume_data", 32'(out_data), 32'h1111);
      drive_edge(); in1 = 16'h3333;
      sample_edge();
      chk("t3_w2_data", 32'(out_data), 32'h2222);
      chk("t3_w3_ack", 32'(ack1), 32'd1);
      drive_edge(); in1 = 16'h4444;
      sample_edge();
      chk("t3_w4_ack", 32'(ack1), 32'd1);
      chk("t3_w4_gnt1", 32'(gnt1), 32'd1);
      drive_edge(); req1 = 1'b0;
      sample_edge();
      chk("t3_burst_release", 32'(gnt1), 32'd0);
      chk("t3_last_data", 32'(out_data), 32'h4444);

      // Requester 1 withdraws before being served under backpressure.
      drive_edge(); out_ready = 1'b0; req0 = 1'b1; in0 = 16'h1234;
      sample_edge();
      chk("t4_idle_gnt0", 32'(gnt0), 32'd0);
      drive_edge();
      sample_edge();
      chk("t4_ack0", 32'(ack0), 32'd1);
      drive_edge(); req0 = 1'b0; req1 = 1'b1; in1 = 16'hA5A5;
      sample_edge();
      chk("t4_gnt0_withdrawn", 32'(gnt0), 32'd1);
      chk("t4_no_ack1_a", 32'(ack1), 32'd0);
      drive_edge();
      sample_edge();
      chk("t4_handover_gnt1", 32'(gnt1), 32'd1);
      chk("t4_no_ack1_b", 32'(ack1), 32'd0);
      drive_edge();
      sample_edge();
      chk("t4_bp_gnt1", 32'(gnt1), 32'd1);
      chk("t4_bp_no_ack1", 32'(ack1), 32'd0);
      chk("t4_bp_data", 32'(out_data), 32'h1234);
      drive_edge(); req1 = 1'b0;
      sample_edge();
      chk("t4_drop_gnt1", 32'(gnt1), 32'd1);
      chk("t4_drop_no_ack1", 32'(ack1), 32'd0);
      drive_edge();
      sample_edge();
      chk("t4_idle_gnt1", 32'(gnt1), 32'd0);
      chk("t4_idle_gnt0b", 32'(gnt0), 32'd0);
      chk("t4_kept_data", 32'(out_data), 32'h1234);
      chk("t4_kept_valid", 32'(out_valid), 32'd1);
      drive_edge(); out_ready = 1'b1;
      sample_edge();
      drive_edge();
      sample_edge();
      chk("t4_final_valid", 32'(out_valid), 32'd0);
      chk("t4_final_data", 32'(out_data), 32'h1234);

      // Reset in the middle of a requester-0 burst.
      drive_edge(); req0 = 1'b1; in0 = 16'h5001;
      sample_edge();
      chk("t5_idle_gnt0", 32'(gnt0), 32'd0);
      drive_edge();
      sample_edge();
      chk("t5_ack_w1", 32'(ack0), 32'd1);
      drive_edge(); in0 = 16'h5002;
      sample_edge();
      chk("t5_ack_w2", 32'(ack0), 32'd1);
      chk("t5_data_w1", 32'(out_data), 32'h5001);
      drive_edge(); in0 = 16'h5003; rst = 1'b1; out_ready = 1'b0;
      sample_edge();
      chk("t5_pending_data", 32'(out_data), 32'h5002);
      drive_edge(); rst = 1'b0; req1 = 1'b1;
      sample_edge();
      chk("t5_rst_gnt0", 32'(gnt0), 32'd0);
      chk("t5_rst_gnt1", 32'(gnt1), 32'd0);
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_data", 32'(out_data), 32'd0);
      drive_edge();
      sample_edge();
      chk("t5_tie_gnt0", 32'(gnt0), 32'd1);
      chk("t5_tie_gnt1", 32'(gnt1), 32'd0);
      drive_edge(); req0 = 1'b0; req1 = 1'b0;

      // Random traffic and backpressure against the scoreboard.
      drive_edge(); rst = 1'b1;
      drive_edge(); rst = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         sample_edge();
         a0 = ack0; a1 = ack1;
         drive_edge();
         if (a0 || !req0) begin
            if ($urandom_range(3) != 0) begin
               req0 = 1'b1;
               in0  = WIDTH'($urandom);
            end else begin
               req0 = 1'b0;
            end
         end else if ($urandom_range(31) == 0) begin
            req0 = 1'b0;
         end
         if (a1 || !req1) begin
            if ($urandom_range(3) != 0) begin
               req1 = 1'b1;
               in1  = WIDTH'($urandom);
            end else begin
               req1 = 1'b0;
            end
         end else if ($urandom_range(31) == 0) begin
            req1 = 1'b0;
         end
         out_ready = ($urandom_range(3) != 0);
      end
      req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
      repeat (4) begin
         sample_edge();
         drive_edge();
      end
      sample_edge();
      chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("t6_out_idle", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
